slide_scan: RTL

Parametrised round-robin A2D channel scanner for the slide-potentiometer front end. It drives the channel select and start/complete handshake of the existing A2D SPI interface and cycles through a configurable list of physical channels. Each conversion result is stored in a per-channel result register. It replaces the fixed six-pot sequencer and adds single-shot or continuous scanning, scan-done signalling and optional two-sample averaging. The A2D interface is instantiated beside this block by the enclosing top level, not inside it.

---
 rtl/slide_pkg.sv | 24 ++
 rtl/slide_avg2.sv | 34 +++
 rtl/slide_scan.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/slide_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : slide_pkg                                                   |
// | Shared types and constants for the slide-pot A2D channel scanner.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package slide_pkg;

  localparam int MAX_CH     = 8;
  localparam int RES_W_DEF  = 12;
  localparam int CHNL_W_DEF = 3;

  // Slot 0 in the low bits; slot 5 maps to physical channel 7.
  localparam logic [6*CHNL_W_DEF-1:0] CH_MAP_DEF = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/slide_avg2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : slide_avg2                                                  |
// | Holds the first of two samples and forms the rounded mean with the   |
// | second sample presented on the same input.                           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module slide_avg2 #(
  parameter int RES_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [RES_W-1:0] sample,
  output logic [RES_W-1:0] avg
);

  logic [RES_W-1:0] first_q;
  logic [RES_W:0]   sum;

  // First-sample register, loaded on the first conversion of a slot.
  always_ff @(posedge clk) begin
    if (rst)       first_q <= '0;
    else if (load) first_q <= sample;
  end

  // One extra bit keeps the rounded sum from overflowing.
  always_comb begin
    sum = {1'b0, first_q} + {1'b0, sample} + {{RES_W{1'b0}}, 1'b1};
    avg = RES_W'(sum >> 1);
  end

endmodule
`default_nettype wire

// File: rtl/slide_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : slide_scan                                                  |
// | Round-robin A2D channel scanner: steps through CH_MAP, drives the    |
// | start/complete handshake and stores each result per slot.            |
// | Optional: define SLIDE_AVG_EN to convert each slot twice and store   |
// | the rounded average.                                                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module slide_scan
  import slide_pkg::*;
#(
  parameter int                       NUM_CH = 6,
  parameter int                       RES_W  = RES_W_DEF,
  parameter int                       CHNL_W = CHNL_W_DEF,
  parameter logic [NUM_CH*CHNL_W-1:0] CH_MAP = CH_MAP_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cont,
  input  logic                    scan_go,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        res,
  output logic [CHNL_W-1:0]       chnnl,
  output logic                    strt_cnv,
  output logic [NUM_CH*RES_W-1:0] pot_res,
  output logic [NUM_CH-1:0]       res_vld,
  output logic                    scan_done,
  output logic                    busy
);

  localparam int                IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                TAB_N = 1 << IDX_W;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_CH - 1);

  scan_state_t       state, nxt_state;
  logic [IDX_W-1:0]  idx, idx_adv, idx_sel;
  logic [CHNL_W-1:0] ch_tab [TAB_N];
  logic              cap, more_conv;
  logic [RES_W-1:0]  cap_val, hold_q;
  logic              strt_d, done_d, busy_d;
  logic [NUM_CH-1:0] vld_d;

  // Channel lookup padded to a power of two so any index value is legal.
  for (genvar t = 0; t < TAB_N; t++) begin : g_tab
    if (t < NUM_CH) begin : g_map
      assign ch_tab[t] = CH_MAP[t*CHNL_W +: CHNL_W];
    end else begin : g_pad
      assign ch_tab[t] = '0;
    end
  end

  assign cap     = (state == ST_WAIT) && cnv_cmplt;
  assign idx_adv = (idx == LAST) ? '0 : idx + 1'b1;
  assign idx_sel = (state == ST_STORE) ? idx_adv : idx;

`ifdef SLIDE_AVG_EN
  logic             phase_q;
  logic [RES_W-1:0] avg_w;

  // Tracks whether the slot's first or second conversion is in flight.
  always_ff @(posedge clk) begin
    if (rst)      phase_q <= 1'b0;
    else if (cap) phase_q <= ~phase_q;
  end

  slide_avg2 #(.RES_W(RES_W)) u_avg (
    .clk    (clk),
    .rst    (rst),
    .load   (cap && !phase_q),
    .sample (res),
    .avg    (avg_w)
  );

  assign more_conv = ~phase_q;
  assign cap_val   = avg_w;
`else
  assign more_conv = 1'b0;
  assign cap_val   = res;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  // Next-state logic; cont is only consulted in IDLE and at the end of a pass.
  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:  if (scan_go || cont) nxt_state = ST_START;
      ST_START: nxt_state = ST_WAIT;
      ST_WAIT:  if (cnv_cmplt) nxt_state = more_conv ? ST_START : ST_STORE;
      ST_STORE: nxt_state = (idx != LAST || cont) ? ST_START : ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  // Output decode, registered below so every port comes straight from a flop.
  always_comb begin
    strt_d = (state == ST_START);
    done_d = (state == ST_STORE) && (idx == LAST);
    busy_d = (nxt_state != ST_IDLE);
    for (int i = 0; i < NUM_CH; i++) begin
      vld_d[i] = (state == ST_STORE) && (idx == IDX_W'(i));
    end
  end

  // Output registers, slot index and channel select.
  always_ff @(posedge clk) begin
    if (rst) begin
      strt_cnv  <= 1'b0;
      res_vld   <= '0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      chnnl     <= '0;
      hold_q    <= '0;
    end else begin
      strt_cnv  <= strt_d;
      res_vld   <= vld_d;
      scan_done <= done_d;
      busy      <= busy_d;
      if (state == ST_STORE)          idx    <= idx_adv;
      if (nxt_state == ST_START)      chnnl  <= ch_tab[idx_sel];
      if (cap && !more_conv)          hold_q <= cap_val;
    end
  end

  // Result register bank, one register per slot.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    logic [RES_W-1:0] slot_q;
    always_ff @(posedge clk) begin
      if (rst)                                           slot_q <= '0;
      else if (state == ST_STORE && idx == IDX_W'(g))    slot_q <= hold_q;
    end
    assign pot_res[g*RES_W +: RES_W] = slot_q;
  end

endmodule
`default_nettype wire
